// File: rtl/alu_pkg.sv
// Operation encoding shared by the ALU arbiter and its requesters.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with a
// single-entry result register returned on the owner's response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int SHW = $clog2(WIDTH);

  logic             full;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last;
  logic [WIDTH-1:0] result;
  logic             zero;

  logic             found;
  logic [IW-1:0]    winner;
  logic             drain;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] alu_res;

  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    sh = b[SHW-1:0];
    case (alu_op_e'(op))
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLT:  res = ($signed(a) < $signed(b)) ? WIDTH'(1'b1) : '0;
      ALU_SLTU: res = (a < b) ? WIDTH'(1'b1) : '0;
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = $unsigned($signed(a) >>> sh);
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IW'((int'(last) + k) % NUM_REQ);
      end else begin
        found  = found;
      end
    end
  end

  // Grant and handshake decode; a drain frees the slot in the same cycle.
  always_comb begin
    drain      = full && rsp_ready[owner];
    can_accept = !full || drain;
    req_ready  = '0;
    if (rst_n && found && can_accept) begin
      req_ready[winner] = 1'b1;
    end else begin
      req_ready = '0;
    end
    accept  = |(req_valid & req_ready);
    alu_res = alu_eval(req_op[int'(winner)*4 +: 4],
                       req_a[int'(winner)*WIDTH +: WIDTH],
                       req_b[int'(winner)*WIDTH +: WIDTH]);
  end

  // Result register, ownership and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full   <= 1'b0;
      owner  <= '0;
      last   <= IW'(NUM_REQ - 1);
      result <= '0;
      zero   <= 1'b1;
    end else if (accept) begin
      full   <= 1'b1;
      owner  <= winner;
      last   <= winner;
      result <= alu_res;
      zero   <= (alu_res == '0);
    end else if (drain) begin
      full   <= 1'b0;
    end else begin
      full   <= full;
    end
  end

  // Response routing to the owner of the held result.
  always_comb begin
    rsp_valid        = '0;
    rsp_valid[owner] = full;
  end

  assign rsp_result = result;
  assign rsp_zero   = zero;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU (op encoding per `alu_pkg::alu_op_e`) between `NUM_REQ` requesters, e.g. the execute stage and a branch/address unit. It does round-robin arbitration over valid/ready request channels and evaluates the granted operation. It holds the result in a single-entry output register and returns it on the owning requester's response channel with valid/ready backpressure. It sits between issue logic and the ALU datapath and owns all sequencing of the shared ALU.

## Interface
- `WIDTH`, 32, operand/result width; power of two, ≥ 8
- `NUM_REQ`, 2, number of requesters; 2..4
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester grant; one-hot or zero
- `req_op`  in  NUM_REQ×4  per-requester `alu_op_e` code
- `req_a`  in  NUM_REQ×WIDTH  per-requester operand A
- `req_b`  in  NUM_REQ×WIDTH  per-requester operand B
- `rsp_valid`  out  NUM_REQ  per-requester response valid; one-hot or zero
- `rsp_ready`  in  NUM_REQ  per-requester response accept
- `rsp_result`  out  WIDTH  result; shared bus, meaningful only where `rsp_valid` is set
- `rsp_zero`  out  1  `rsp_result == 0`

## Operation
- State:
  - `full`: result register occupied
  - `owner`: requester index of the held result
  - `result`: WIDTH-bit held result
  - `last`: index of the last granted requester
- `drain` = `full && rsp_ready[owner]`.
- `can_accept` = `!full || drain`. This allows back-to-back throughput of one op per cycle.
- Arbitration (combinational):
  - Scan requesters starting at `(last+1) mod NUM_REQ` and wrapping.
  - The first one with `req_valid` set wins.
  - `req_ready[winner] = can_accept`; all other `req_ready` bits are 0.
- Accept (`req_valid[i] && req_ready[i]`):
  - `result` ← ALU(`req_op[i]`, `req_a[i]`, `req_b[i]`)
  - `owner` ← i, `last` ← i, `full` ← 1
- Drain without accept: `full` ← 0. `result` and `owner` are retained but not visible.
- `rsp_valid[owner] = full`; all other bits are 0.
- ALU semantics, all modulo 2^WIDTH:
  - ADD: a+b
  - SUB: a−b
  - AND, OR, XOR: bitwise
  - SLT: signed a<b, result is {0…,1} or 0
  - SLTU: unsigned compare, same result form as SLT
  - SLL, SRL: logical shift
  - SRA: arithmetic shift
  - Shift amount is `b[log2(WIDTH)-1:0]`; upper bits of b are ignored.
  - Codes 4'b1010–4'b1111: result 0, and the accept still completes normally.
- Requesters hold `req_op/a/b` stable while `req_valid` is high and `req_ready` is low. The arbiter does not latch operands before grant.
- No request is starved. With all requesters continuously valid and `rsp_ready` held high, grants rotate strictly 0,1,…,NUM_REQ−1,0,…

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `full`=0, `result`=0, `owner`=0
  - `last`=NUM_REQ−1, so requester 0 has first priority
  - All `rsp_valid` are 0; `rsp_result`=0, `rsp_zero`=1
- Reset asserted mid-operation drops any held result with no response. `req_ready` is 0 while `rst_n`=0.
- Latency: accept at edge N → `rsp_valid[owner]` and `rsp_result` valid after edge N, i.e. in cycle N+1.
- Response stability: while `rsp_valid[k]`=1 and `rsp_ready[k]`=0, `rsp_result`, `rsp_zero` and `owner` hold unchanged. No new grant is issued in this state.
- Simultaneous drain and accept in the same cycle: the new result replaces the old at the edge, and `rsp_valid` moves to the new owner (possibly the same one) with no bubble.
- `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. No path exists from `req_ready` to `req_valid`.
- A requester whose valid drops before grant loses its turn; `last` is unchanged.

## Test plan
- Reset then single op: r0 issues ADD a=5, b=7 → `req_ready[0]`=1 in the same cycle; next cycle `rsp_valid`=01, `rsp_result`=12, `rsp_zero`=0.
- Op coverage with WIDTH=32:
  - SUB 3−5 → 0xFFFFFFFE
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0
  - SRA 0x80000000 by b=0x21 → shift 1 → 0xC0000000
  - SLL 1 by 31 → 0x80000000
  - Code 4'b1111 → 0 with `rsp_zero`=1
- Contention: r0 and r1 valid continuously with `rsp_ready`=11 → grants alternate 0,1,0,1 one per cycle, and each response is routed to the correct `rsp_valid` bit.
- Backpressure: hold `rsp_ready[0]`=0 for 3 cycles with r1 pending → `rsp_result` stable and `req_ready`=00 throughout; when `rsp_ready[0]` goes to 1, r1 is granted in that same cycle and its result appears the next cycle.
- Reset mid-operation: `rst_n`=0 while `full`=1 and `rsp_ready`=0 → next cycle all `rsp_valid`=0 and `rsp_result`=0; the first post-reset grant goes to r0 even though r1 was last.
- Valid withdrawal: r1 asserts valid for one cycle while `full` is blocked, then deasserts → no r1 response; a later r0 request is granted normally.
